// File: rtl/ccd_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : ccd_frame_writer
//  Description : Packs 8-bit CCD pixel bytes into DSIZE-bit words for the
//                SDRAM write FIFO. The write-port address/FIFO is reloaded
//                only during vertical blank. Line, byte and frame counts
//                are tracked, and words dropped on FIFO-full are flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccd_frame_writer #(
  parameter int DSIZE       = 16,
  parameter int LOAD_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             iSTART,
  input  logic             iFVAL,
  input  logic             iLVAL,
  input  logic [7:0]       iDATA,
  input  logic             iFULL,
  output logic [DSIZE-1:0] oWR_DATA,
  output logic             oWR,
  output logic             oWR_LOAD,
  output logic [11:0]      oX_CNT,
  output logic [11:0]      oY_CNT,
  output logic [15:0]      oFRAME_CNT,
  output logic             oOVERFLOW,
  output logic             oBUSY
);

  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LW-1:0] c_LOAD_LAST = LW'(LOAD_CYCLES - 1);
  localparam logic [11:0]   c_CNT_MAX   = 12'hFFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_LOAD    = 3'd2,
    S_SYNC    = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_fval_prev;
  logic             r_lval_prev;
  logic [LW-1:0]    r_load_cnt;
  logic             r_phase;
  logic [7:0]       r_lo_byte;
  logic [DSIZE-1:0] r_wr_data;
  logic             r_wr;
  logic             r_wr_load;
  logic [11:0]      r_x_cnt;
  logic [11:0]      r_y_cnt;
  logic [15:0]      r_frame_cnt;
  logic             r_overflow;

  logic             w_fval_rise;
  logic             w_fval_fall;
  logic             w_lval_fall;
  logic             w_byte;
  logic [DSIZE-1:0] w_word;

  assign w_fval_rise = iFVAL & ~r_fval_prev;
  assign w_fval_fall = ~iFVAL & r_fval_prev;
  assign w_lval_fall = ~iLVAL & r_lval_prev;
  assign w_byte      = iFVAL & iLVAL;
  // High byte is the newest pixel, low byte the one stored on phase 0.
  assign w_word      = DSIZE'({iDATA, r_lo_byte});

  assign oWR_DATA   = r_wr_data;
  assign oWR        = r_wr;
  assign oWR_LOAD   = r_wr_load;
  assign oX_CNT     = r_x_cnt;
  assign oY_CNT     = r_y_cnt;
  assign oFRAME_CNT = r_frame_cnt;
  assign oOVERFLOW  = r_overflow;
  assign oBUSY      = (r_state != S_IDLE);

  // Delayed copies of the sync inputs for edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fval_prev <= 1'b0;
      r_lval_prev <= 1'b0;
    end else begin
      r_fval_prev <= iFVAL;
      r_lval_prev <= iLVAL;
    end
  end

  // Capture state machine with byte packing, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_load_cnt  <= '0;
      r_phase     <= 1'b0;
      r_lo_byte   <= '0;
      r_wr_data   <= '0;
      r_wr        <= 1'b0;
      r_wr_load   <= 1'b0;
      r_x_cnt     <= '0;
      r_y_cnt     <= '0;
      r_frame_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      if (!iLVAL) r_x_cnt <= '0;
      if (w_lval_fall) r_phase <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (iSTART) r_state <= S_ARM;
        end

        // Wait for vertical blank so a reload never lands mid-frame.
        S_ARM: begin
          if (!iFVAL) begin
            r_state    <= S_LOAD;
            r_wr_load  <= 1'b1;
            r_load_cnt <= '0;
          end
        end

        S_LOAD: begin
          r_overflow <= 1'b0;
          if (r_load_cnt == c_LOAD_LAST) begin
            r_wr_load <= 1'b0;
            r_state   <= S_SYNC;
          end else begin
            r_load_cnt <= r_load_cnt + 1'b1;
          end
        end

        S_SYNC: begin
          if (w_fval_rise) begin
            r_state <= S_CAPTURE;
            r_x_cnt <= '0;
            r_y_cnt <= '0;
            r_phase <= 1'b0;
          end
        end

        S_CAPTURE: begin
          if (w_byte) begin
            if (r_x_cnt != c_CNT_MAX) r_x_cnt <= r_x_cnt + 1'b1;
            r_phase <= ~r_phase;
            if (!r_phase) begin
              r_lo_byte <= iDATA;
            end else if (iFULL) begin
              r_overflow <= 1'b1;
            end else begin
              r_wr      <= 1'b1;
              r_wr_data <= w_word;
            end
          end
          if (w_lval_fall && (r_y_cnt != c_CNT_MAX)) r_y_cnt <= r_y_cnt + 1'b1;
          // Frame end; iSTART only decides what follows, never aborts a frame.
          if (w_fval_fall) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            if (iSTART) begin
              r_state    <= S_LOAD;
              r_wr_load  <= 1'b1;
              r_load_cnt <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccd_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccd_frame_writer
//  Description : Directed self-checking bench for ccd_frame_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ccd_frame_writer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        iSTART;
  logic        iFVAL;
  logic        iLVAL;
  logic [7:0]  iDATA;
  logic        iFULL;
  logic [15:0] oWR_DATA;
  logic        oWR;
  logic        oWR_LOAD;
  logic [11:0] oX_CNT;
  logic [11:0] oY_CNT;
  logic [15:0] oFRAME_CNT;
  logic        oOVERFLOW;
  logic        oBUSY;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int load_cnt = 0;

  ccd_frame_writer #(.DSIZE(16), .LOAD_CYCLES(4)) u_dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .iSTART     (iSTART),
    .iFVAL      (iFVAL),
    .iLVAL      (iLVAL),
    .iDATA      (iDATA),
    .iFULL      (iFULL),
    .oWR_DATA   (oWR_DATA),
    .oWR        (oWR),
    .oWR_LOAD   (oWR_LOAD),
    .oX_CNT     (oX_CNT),
    .oY_CNT     (oY_CNT),
    .oFRAME_CNT (oFRAME_CNT),
    .oOVERFLOW  (oOVERFLOW),
    .oBUSY      (oBUSY)
  );

  always #5 CLK = ~CLK;

  // Count write and load cycles away from the active edge.
  always @(negedge CLK) begin
    if (oWR)      wr_cnt   <= wr_cnt + 1;
    if (oWR_LOAD) load_cnt <= load_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive one line of bytes 0x11,0x22,... ; iFULL asserted on byte full_at.
  task automatic send_line(input int nbytes, input int full_at);
    logic [7:0] b_cur;
    logic [7:0] b_prev;
    for (int k = 0; k < nbytes; k++) begin
      b_cur  = 8'((k + 1) * 17);
      b_prev = 8'(k * 17);
      iLVAL  = 1'b1;
      iDATA  = b_cur;
      iFULL  = (k == full_at);
      tick();
      if ((k % 2) == 1) begin
        if (k == full_at) begin
          check("wr_dropped", 32'(oWR), 32'd0);
        end else begin
          check("wr_pulse", 32'(oWR), 32'd1);
          check("wr_data", 32'(oWR_DATA), 32'({b_cur, b_prev}));
        end
      end else begin
        check("wr_idle", 32'(oWR), 32'd0);
      end
    end
    iFULL = 1'b0;
    check("x_cnt_line", 32'(oX_CNT), 32'(nbytes));
    iLVAL = 1'b0;
    iDATA = 8'h00;
    tick();
    check("x_cnt_clear", 32'(oX_CNT), 32'd0);
    tick();
  endtask

  initial begin
    int l0;
    int w0;
    RESET  = 1'b1;
    iSTART = 1'b0;
    iFVAL  = 1'b0;
    iLVAL  = 1'b0;
    iDATA  = 8'h00;
    iFULL  = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(oBUSY), 32'd0);
    check("rst_load", 32'(oWR_LOAD), 32'd0);
    check("rst_wr", 32'(oWR), 32'd0);
    check("rst_frame", 32'(oFRAME_CNT), 32'd0);
    RESET = 1'b0;
    tick();
    check("idle_busy", 32'(oBUSY), 32'd0);

    // Start in vertical blank: 4-cycle load, then SYNC.
    l0 = load_cnt;
    iSTART = 1'b1;
    tick();
    check("arm_busy", 32'(oBUSY), 32'd1);
    check("arm_noload", 32'(oWR_LOAD), 32'd0);
    tick();
    check("load_on", 32'(oWR_LOAD), 32'd1);
    repeat (3) tick();
    check("load_hold", 32'(oWR_LOAD), 32'd1);
    tick();
    check("load_off", 32'(oWR_LOAD), 32'd0);
    check("sync_busy", 32'(oBUSY), 32'd1);
    repeat (2) tick();
    check("load_len", 32'(load_cnt - l0), 32'd4);

    // Frame 1: two lines of 4 bytes.
    w0 = wr_cnt;
    iFVAL = 1'b1;
    repeat (2) tick();
    send_line(4, -1);
    send_line(4, -1);
    check("y_cnt", 32'(oY_CNT), 32'd2);
    iFVAL = 1'b0;
    tick();
    check("frame1", 32'(oFRAME_CNT), 32'd1);
    check("reload", 32'(oWR_LOAD), 32'd1);
    tick();
    check("wr_count1", 32'(wr_cnt - w0), 32'd4);
    repeat (5) tick();

    // Frame 2: odd-length line, then a write lost to FIFO full.
    iFVAL = 1'b1;
    repeat (2) tick();
    check("y_clear", 32'(oY_CNT), 32'd0);
    send_line(5, -1);
    send_line(4, -1);
    check("ovf_none", 32'(oOVERFLOW), 32'd0);
    w0 = wr_cnt;
    send_line(4, 3);
    check("ovf_set", 32'(oOVERFLOW), 32'd1);
    check("wr_count_full", 32'(wr_cnt - w0), 32'd1);
    iFVAL = 1'b0;
    tick();
    check("frame2", 32'(oFRAME_CNT), 32'd2);
    check("ovf_hold", 32'(oOVERFLOW), 32'd1);
    repeat (5) tick();
    check("ovf_cleared", 32'(oOVERFLOW), 32'd0);
    check("load_done2", 32'(oWR_LOAD), 32'd0);

    // Frame 3: iSTART dropped mid-frame.
    iFVAL = 1'b1;
    repeat (2) tick();
    iSTART = 1'b0;
    send_line(4, -1);
    check("stop_busy", 32'(oBUSY), 32'd1);
    iFVAL = 1'b0;
    l0 = load_cnt;
    tick();
    check("frame3", 32'(oFRAME_CNT), 32'd3);
    check("stop_idle", 32'(oBUSY), 32'd0);
    repeat (6) tick();
    check("stop_noload", 32'(load_cnt - l0), 32'd0);

    // Start while a frame is already running: wait for blank.
    iFVAL = 1'b1;
    repeat (2) tick();
    iSTART = 1'b1;
    l0 = load_cnt;
    repeat (6) tick();
    check("midframe_busy", 32'(oBUSY), 32'd1);
    check("midframe_noload", 32'(load_cnt - l0), 32'd0);
    iFVAL = 1'b0;
    tick();
    check("blank_load", 32'(oWR_LOAD), 32'd1);
    repeat (5) tick();
    check("blank_len", 32'(load_cnt - l0), 32'd4);

    // Reset in the middle of a line.
    iFVAL = 1'b1;
    repeat (2) tick();
    iLVAL = 1'b1;
    iDATA = 8'hAA;
    tick();
    iDATA = 8'hBB;
    tick();
    check("pre_rst_wr", 32'(oWR), 32'd1);
    check("pre_rst_data", 32'(oWR_DATA), 32'h0000BBAA);
    iDATA = 8'hCC;
    RESET = 1'b1;
    tick();
    check("mrst_wr", 32'(oWR), 32'd0);
    check("mrst_data", 32'(oWR_DATA), 32'd0);
    check("mrst_x", 32'(oX_CNT), 32'd0);
    check("mrst_frame", 32'(oFRAME_CNT), 32'd0);
    check("mrst_busy", 32'(oBUSY), 32'd0);
    RESET = 1'b0;
    iLVAL = 1'b0;
    l0 = load_cnt;
    repeat (5) tick();
    check("post_rst_noload", 32'(load_cnt - l0), 32'd0);
    check("post_rst_arm", 32'(oBUSY), 32'd1);
    iFVAL = 1'b0;
    repeat (2) tick();
    check("post_rst_load", 32'(oWR_LOAD), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccd_frame_writer.md
CCD_FRAME_WRITER -- requirements
Module: ccd_frame_writer

Interface
REQ-001 SHALL have parameter DSIZE, default 16, SDRAM write-port word width.
REQ-002 SHALL have parameter LOAD_CYCLES, default 4, width of the write-port load/clear pulse in clock cycles.
REQ-003 SHALL have port CLK  input  1  sole clock; the block and the SDRAM write-FIFO write side run on it.
REQ-004 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port iSTART  input  1  capture enable (level).
REQ-006 SHALL have port iFVAL  input  1  sensor frame valid.
REQ-007 SHALL have port iLVAL  input  1  sensor line valid.
REQ-008 SHALL have port iDATA  input  8  pixel byte; valid when iFVAL&iLVAL.
REQ-009 SHALL have port iFULL  input  1  write-FIFO full (from SDRAM controller write port).
REQ-010 SHALL have port oWR_DATA  output  DSIZE  packed word to write-FIFO.
REQ-011 SHALL have port oWR  output  1  write-FIFO write request, one cycle per word.
REQ-012 SHALL have port oWR_LOAD  output  1  write-port address load and FIFO clear.
REQ-013 SHALL have port oX_CNT  output  12  byte count within current line.
REQ-014 SHALL have port oY_CNT  output  12  completed-line count within current frame.
REQ-015 SHALL have port oFRAME_CNT  output  16  completed-frame count.
REQ-016 SHALL have port oOVERFLOW  output  1  sticky dropped-word flag.
REQ-017 SHALL have port oBUSY  output  1  high in every state except IDLE.

Function
REQ-018 SHALL register iFVAL/iLVAL into prev copies each cycle; rising/falling edges SHALL be detected as current vs prev.
REQ-019 SHALL implement states IDLE, ARM, LOAD, SYNC, CAPTURE.
REQ-020 IDLE: SHALL go to ARM when iSTART=1.
REQ-021 ARM: SHALL go to LOAD on first cycle with iFVAL=0 (vertical blank); never loads mid-frame.
REQ-022 LOAD: SHALL hold oWR_LOAD=1 for exactly LOAD_CYCLES cycles, clear oOVERFLOW, then go to SYNC; oWR_LOAD=0 in all other states.
REQ-023 SYNC: SHALL go to CAPTURE on iFVAL rising edge, clearing oY_CNT, oX_CNT, byte phase.
REQ-024 CAPTURE: on iFVAL falling edge SHALL increment oFRAME_CNT (16-bit wrap 0xFFFF->0) and go to LOAD if iSTART=1, else IDLE; iSTART dropping mid-frame SHALL NOT abort the frame.
REQ-025 Packing, CAPTURE only: each byte with iFVAL&iLVAL toggles phase; phase 0 stores byte as low half; phase 1 forms {iDATA, stored byte}.
REQ-026 Completed word SHALL appear on oWR_DATA with oWR=1 on the next cycle (latency 1); oWR_DATA holds last word otherwise.
REQ-027 If iFULL=1 on the cycle a word completes, oWR SHALL stay 0, the word is dropped, oOVERFLOW SHALL set and hold until RESET or LOAD.
REQ-028 Byte phase SHALL reset to 0 on every iLVAL falling edge; a trailing odd byte is discarded without write.
REQ-029 oX_CNT SHALL increment per valid byte in CAPTURE, clear when iLVAL=0; saturate at 4095.
REQ-030 oY_CNT SHALL increment on iLVAL falling edge in CAPTURE; saturate at 4095.
REQ-031 Bytes outside CAPTURE SHALL be ignored; no oWR outside CAPTURE (except the registered final word issued on the cycle after leaving).

Reset
REQ-032 RESET=1 at a clock edge SHALL force IDLE and all outputs, counters, prev registers, phase and stored byte to 0, including mid-frame or mid-LOAD.
REQ-033 After RESET release mid-frame, block SHALL wait (via ARM) for iFVAL=0 before any load or write.

Verification
REQ-034 iSTART=1, iFVAL=0 -> oWR_LOAD high exactly 4 cycles, then SYNC, oBUSY=1.
REQ-035 Frame 2 lines x 4 bytes 11,22,33,44 -> oWR words 0x2211,0x4433 per line, 4 oWR pulses, each 1 cycle after second byte; oY_CNT=2; oFRAME_CNT=1.
REQ-036 Line of 5 bytes -> 2 writes, fifth byte dropped; next line starts phase 0.
REQ-037 iFULL=1 when second word completes -> only 1 oWR, oOVERFLOW=1 until next LOAD clears it.
REQ-038 iSTART=1 with iFVAL already 1 -> no oWR_LOAD until iFVAL=0; RESET mid-CAPTURE -> all outputs 0 next cycle, IDLE.
REQ-039 iSTART dropped mid-frame -> frame finishes, oFRAME_CNT increments, return to IDLE, no further oWR_LOAD.
